ysyx_23060077_riscv_lsu: RTL and testbench

- Load/store unit sitting directly downstream of the decode stage.
- Consumes lsu_opt, funct3, rs1/rs2 operands and the immediate, computes the effective address, and performs one data-memory access per instruction over a valid/ready request plus response-valid bus.
- Returns aligned, sign/zero-extended load data to writeback.
- Non-memory ops (LSU_OPT_NONE, LSU_OPT_SYS) pass through with zero memory traffic.

---
 rtl/ysyx_23060077_riscv_lsu.sv | 173 +++++++++++++++++
 tb/tb_ysyx_23060077_riscv_lsu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_riscv_lsu.sv
// Load/store unit: computes the effective address, issues one data-memory access
// per instruction over a valid/ready bus, and returns extended load data to writeback.

`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 2
`endif
`ifndef LSU_OPT_NONE
`define LSU_OPT_NONE  2'd0
`endif
`ifndef LSU_OPT_LOAD
`define LSU_OPT_LOAD  2'd1
`endif
`ifndef LSU_OPT_STORE
`define LSU_OPT_STORE 2'd2
`endif
`ifndef LSU_OPT_SYS
`define LSU_OPT_SYS   2'd3
`endif

module ysyx_23060077_riscv_lsu #(
   parameter int XLEN          = 32,
   parameter int LSU_OPT_WIDTH = `LSU_OPT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LSU_OPT_WIDTH-1:0] lsu_opt,
   input  logic [2:0]               funct3,
   input  logic [XLEN-1:0]          rs1_data,
   input  logic [XLEN-1:0]          rs2_data,
   input  logic [XLEN-1:0]          imm,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_we,
   output logic [XLEN-1:0]          mem_addr,
   output logic [XLEN-1:0]          mem_wdata,
   output logic [3:0]               mem_wstrb,
   input  logic                     mem_rsp_valid,
   input  logic [XLEN-1:0]          mem_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_rdata,
   output logic                     out_misalign
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   state_t          state, state_nxt;
   size_t           size;
   logic [XLEN-1:0] ea;
   logic            is_load, is_store, misalign, mem_go;
   logic [XLEN-1:0] wdata_nxt;
   logic [3:0]      wstrb_nxt;
   logic [2:0]      funct3_q;
   logic [1:0]      ea_lo_q;
   logic            load_q;
   logic [XLEN-1:0] rdata_sh, load_ext;
   logic            accept, rsp_fire;

   assign ea       = rs1_data + imm;
   assign is_load  = (lsu_opt == `LSU_OPT_LOAD);
   assign is_store = (lsu_opt == `LSU_OPT_STORE);

   // Undefined funct3 codes fall through to word size.
   always_comb begin
      case (funct3)
         3'b000, 3'b100: size = SZ_B;
         3'b001, 3'b101: size = SZ_H;
         default:        size = SZ_W;
      endcase
   end

   assign misalign = ((size == SZ_H) && ea[0]) || ((size == SZ_W) && (ea[1:0] != 2'b00));
   assign mem_go   = (is_load || is_store) && !misalign;

   always_comb begin
      wdata_nxt = rs2_data;
      wstrb_nxt = 4'b0000;
      if (is_store) begin
         case (size)
            SZ_B: begin
               wdata_nxt = {(XLEN/8){rs2_data[7:0]}};
               wstrb_nxt = 4'b0001 << ea[1:0];
            end
            SZ_H: begin
               wdata_nxt = {(XLEN/16){rs2_data[15:0]}};
               wstrb_nxt = ea[1] ? 4'b1100 : 4'b0011;
            end
            default: wstrb_nxt = 4'b1111;
         endcase
      end
   end

   assign rdata_sh = mem_rdata >> {ea_lo_q, 3'b000};

   always_comb begin
      case (funct3_q)
         3'b000:  load_ext = {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
         3'b001:  load_ext = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
         3'b100:  load_ext = {{(XLEN-8){1'b0}}, rdata_sh[7:0]};
         3'b101:  load_ext = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
         default: load_ext = rdata_sh;
      endcase
   end

   // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt     = state;
      in_ready      = 1'b0;
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
      accept        = 1'b0;
      rsp_fire      = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = mem_go ? S_REQ : S_DONE;
            end
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               rsp_fire  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         default: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wstrb    <= 4'b0000;
         funct3_q     <= 3'b000;
         ea_lo_q      <= 2'b00;
         load_q       <= 1'b0;
         out_rdata    <= '0;
         out_misalign <= 1'b0;
      end else if (accept) begin
         mem_we       <= is_store && mem_go;
         mem_addr     <= {ea[XLEN-1:2], 2'b00};
         mem_wdata    <= wdata_nxt;
         mem_wstrb    <= mem_go ? wstrb_nxt : 4'b0000;
         funct3_q     <= funct3;
         ea_lo_q      <= ea[1:0];
         load_q       <= is_load;
         out_rdata    <= '0;
         out_misalign <= (is_load || is_store) && misalign;
      end else if (rsp_fire && load_q) begin
         out_rdata    <= load_ext;
      end
   end

endmodule

// File: tb/tb_ysyx_23060077_riscv_lsu.sv
// Self-checking bench for the LSU: table-driven transactions with a scoreboard,
// plus hand-written reset and stale-response sequences.

`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 2
`endif
`ifndef LSU_OPT_NONE
`define LSU_OPT_NONE  2'd0
`endif
`ifndef LSU_OPT_LOAD
`define LSU_OPT_LOAD  2'd1
`endif
`ifndef LSU_OPT_STORE
`define LSU_OPT_STORE 2'd2
`endif
`ifndef LSU_OPT_SYS
`define LSU_OPT_SYS   2'd3
`endif

module tb_ysyx_23060077_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [1:0]  lsu_opt;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data, imm;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        out_valid, out_ready;
   logic [31:0] out_rdata;
   logic        out_misalign;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ysyx_23060077_riscv_lsu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .lsu_opt      (lsu_opt),
      .funct3       (funct3),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .imm          (imm),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata    (mem_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rdata    (out_rdata),
      .out_misalign (out_misalign)
   );

   typedef struct {
      logic [1:0]  opt;
      logic [2:0]  f3;
      logic [31:0] rs1, imm, rs2, rdata;
      int          req_stall, out_stall;
      bit          exp_req, exp_we;
      logic [31:0] exp_addr, exp_wdata;
      logic [3:0]  exp_wstrb;
      bit          chk_wdata;
      logic [31:0] exp_rdata;
      bit          exp_mis;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      bit          mis;
   } sb_t;

   vec_t vecs[$];
   sb_t  sbq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] opt, input logic [2:0] f3,
                               input logic [31:0] rs1, input logic [31:0] im,
                               input logic [31:0] rs2, input logic [31:0] rdata,
                               input int rst, input int ost, input bit req, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input bit chkw,
                               input logic [31:0] exp_rdata, input bit mis);
      vec_t v;
      v.opt = opt; v.f3 = f3; v.rs1 = rs1; v.imm = im; v.rs2 = rs2; v.rdata = rdata;
      v.req_stall = rst; v.out_stall = ost; v.exp_req = req; v.exp_we = we;
      v.exp_addr = addr; v.exp_wdata = wdata; v.exp_wstrb = wstrb; v.chk_wdata = chkw;
      v.exp_rdata = exp_rdata; v.exp_mis = mis;
      return v;
   endfunction

   // Drives one instruction and plays memory and writeback around it, including stalls
   // and stray response pulses in states where the DUT must ignore them.
   task automatic run_vec(input vec_t v, input int idx);
      sb_t         e, got;
      int          cyc, rs, os, exp_lat;
      bit          req_seen, out_seen, out_done, rsp_pend;
      logic [36:0] req0;
      logic [31:0] wd0, rd0;
      logic        mis0;
      string       tag;
      tag = $sformatf("v%0d", idx);
      cyc = 0; rs = 0; os = 0;
      req_seen = 0; out_seen = 0; out_done = 0; rsp_pend = 0;
      req0 = '0; wd0 = '0; rd0 = '0; mis0 = 1'b0;
      exp_lat = v.exp_req ? 3 + v.req_stall : 1;
      @(negedge clk);
      in_valid = 1'b1; lsu_opt = v.opt; funct3 = v.f3;
      rs1_data = v.rs1; imm = v.imm; rs2_data = v.rs2;
      check({tag, "_in_ready_idle"}, in_ready, 1);
      e.rdata = v.exp_rdata; e.mis = v.exp_mis;
      sbq.push_back(e);
      @(posedge clk);
      while (!out_done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         in_valid      = 1'b0;
         mem_rsp_valid = 1'b0;
         mem_rdata     = $urandom;
         if (rsp_pend) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = v.rdata;
            rsp_pend      = 0;
         end
         check({tag, "_in_ready_busy"}, in_ready, 0);
         if (mem_req_valid) begin
            if (!req_seen) begin
               req_seen = 1;
               req0 = {mem_we, mem_wstrb, mem_addr};
               wd0  = mem_wdata;
               check({tag, "_we"},    mem_we,    v.exp_we);
               check({tag, "_addr"},  mem_addr,  v.exp_addr);
               check({tag, "_wstrb"}, mem_wstrb, v.exp_wstrb);
               if (v.chk_wdata) check({tag, "_wdata"}, mem_wdata, v.exp_wdata);
            end else begin
               check({tag, "_req_hold"},   {mem_we, mem_wstrb, mem_addr}, req0);
               check({tag, "_wdata_hold"}, mem_wdata, wd0);
            end
            if (rs < v.req_stall) begin
               rs++;
               mem_req_ready = 1'b0;
               mem_rsp_valid = 1'b1;
            end else begin
               mem_req_ready = 1'b1;
               rsp_pend      = 1;
            end
         end else begin
            mem_req_ready = 1'b0;
         end
         if (out_valid) begin
            if (!out_seen) begin
               out_seen = 1;
               rd0 = out_rdata; mis0 = out_misalign;
               check({tag, "_latency"}, cyc, exp_lat);
            end else begin
               check({tag, "_out_hold"}, {out_misalign, out_rdata}, {mis0, rd0});
            end
            if (os < v.out_stall) begin
               os++;
               out_ready     = 1'b0;
               mem_rsp_valid = 1'b1;
            end else begin
               out_ready = 1'b1;
               out_done  = 1;
               if (sbq.size() == 0) begin
                  check({tag, "_sb_underflow"}, 1, 0);
               end else begin
                  got = sbq.pop_front();
                  check({tag, "_rdata"},    out_rdata,    got.rdata);
                  check({tag, "_misalign"}, out_misalign, got.mis);
               end
            end
         end else begin
            out_ready = 1'b0;
         end
      end
      if (!out_done) check({tag, "_timeout"}, 1, 0);
      check({tag, "_mem_traffic"}, req_seen, v.exp_req);
      @(negedge clk);
      out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      check({tag, "_back_idle"}, {in_ready, out_valid, mem_req_valid}, 3'b100);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_req_valid"}, mem_req_valid, 0);
      check({tag, "_mem_payload"}, {mem_we, mem_wstrb, mem_addr}, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_out"}, {out_valid, out_misalign, out_rdata}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cyc;
      rst_n = 1'b0; in_valid = 1'b0; lsu_opt = `LSU_OPT_NONE; funct3 = 3'b000;
      rs1_data = '0; rs2_data = '0; imm = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;

      //        opt             f3      rs1           imm           rs2           rdata        rst ost req we addr          wdata         wstrb  chk exp_rdata     mis
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b010, 32'h8000_0000, 32'd4,        32'h0,        32'hDEAD_BEEF, 0, 0, 1, 0, 32'h8000_0004, 32'h0,        4'h0, 0, 32'hDEAD_BEEF, 0));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b000, 32'h0000_1000, 32'd3,        32'h0,        32'h8000_0000, 0, 0, 1, 0, 32'h0000_1000, 32'h0,        4'h0, 0, 32'hFFFF_FF80, 0));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b100, 32'h0000_1000, 32'd3,        32'h0,        32'h8000_0000, 0, 0, 1, 0, 32'h0000_1000, 32'h0,        4'h0, 0, 32'h0000_0080, 0));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b001, 32'h0000_1000, 32'd2,        32'h0,        32'h8001_0000, 0, 0, 1, 0, 32'h0000_1000, 32'h0,        4'h0, 0, 32'hFFFF_8001, 0));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b101, 32'h0000_1000, 32'd2,        32'h0,        32'h8001_0000, 0, 0, 1, 0, 32'h0000_1000, 32'h0,        4'h0, 0, 32'h0000_8001, 0));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b000, 32'h0000_1000, 32'd1,        32'h0,        32'h0000_7F00, 0, 0, 1, 0, 32'h0000_1000, 32'h0,        4'h0, 0, 32'h0000_007F, 0));
      vecs.push_back(mk(`LSU_OPT_STORE, 3'b001, 32'h0000_2000, 32'd2,        32'h1234_5678, 32'hA5A5_A5A5, 0, 0, 1, 1, 32'h0000_2000, 32'h5678_5678, 4'hC, 1, 32'h0,         0));
      vecs.push_back(mk(`LSU_OPT_STORE, 3'b000, 32'h0000_2005, 32'hFFFF_FFFC, 32'h1234_5678, 32'hA5A5_A5A5, 0, 0, 1, 1, 32'h0000_2000, 32'h7878_7878, 4'h2, 1, 32'h0,         0));
      vecs.push_back(mk(`LSU_OPT_STORE, 3'b010, 32'hFFFF_FFFC, 32'd8,        32'hCAFE_F00D, 32'h5A5A_5A5A, 0, 0, 1, 1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 1, 32'h0,         0));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b010, 32'h0000_3000, 32'd1,        32'h0,        32'h1111_1111, 0, 0, 0, 0, 32'h0,         32'h0,        4'h0, 0, 32'h0,         1));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b001, 32'h0000_3000, 32'd3,        32'h0,        32'h1111_1111, 0, 0, 0, 0, 32'h0,         32'h0,        4'h0, 0, 32'h0,         1));
      vecs.push_back(mk(`LSU_OPT_STORE, 3'b010, 32'h0000_3000, 32'd2,        32'hFFFF_FFFF, 32'h1111_1111, 0, 0, 0, 0, 32'h0,         32'h0,        4'h0, 0, 32'h0,         1));
      vecs.push_back(mk(`LSU_OPT_SYS,   3'b010, 32'h0000_3001, 32'd0,        32'h0,        32'h1111_1111, 0, 0, 0, 0, 32'h0,         32'h0,        4'h0, 0, 32'h0,         0));
      vecs.push_back(mk(`LSU_OPT_NONE,  3'b010, 32'h0000_3001, 32'd0,        32'h0,        32'h1111_1111, 0, 0, 0, 0, 32'h0,         32'h0,        4'h0, 0, 32'h0,         0));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b011, 32'h0000_1000, 32'd4,        32'h0,        32'h1234_ABCD, 0, 0, 1, 0, 32'h0000_1004, 32'h0,        4'h0, 0, 32'h1234_ABCD, 0));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b011, 32'h0000_1000, 32'd2,        32'h0,        32'h1234_ABCD, 0, 0, 0, 0, 32'h0,         32'h0,        4'h0, 0, 32'h0,         1));
      vecs.push_back(mk(`LSU_OPT_LOAD,  3'b010, 32'h0000_4000, 32'd8,        32'h0,        32'h0BAD_F00D, 5, 3, 1, 0, 32'h0000_4008, 32'h0,        4'h0, 0, 32'h0BAD_F00D, 0));
      vecs.push_back(mk(`LSU_OPT_STORE, 3'b001, 32'h0000_5000, 32'd0,        32'h0000_BEEF, 32'h7777_7777, 2, 2, 1, 1, 32'h0000_5000, 32'hBEEF_BEEF, 4'h3, 1, 32'h0,         0));
      vecs.push_back(mk(`LSU_OPT_SYS,   3'b000, 32'h0,         32'd0,        32'h0,        32'h0,         0, 3, 0, 0, 32'h0,         32'h0,        4'h0, 0, 32'h0,         0));

      #12;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Reset in the middle of a store request, then a stale response after release.
      @(negedge clk);
      in_valid = 1'b1; lsu_opt = `LSU_OPT_STORE; funct3 = 3'b000;
      rs1_data = 32'h0000_6001; imm = 32'd0; rs2_data = 32'h0000_00AB;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!mem_req_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_pre_req_valid", mem_req_valid, 1);
      check("rst_pre_we", mem_we, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("stale_rsp_idle", {in_ready, out_valid, mem_req_valid}, 3'b100);
      check("stale_rsp_rdata", out_rdata, 0);

      // Recovery after the abort.
      run_vec(vecs[0], 100);

      check("sb_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
